// File: rtl/fft_fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_fifo_pkg: shared constants, prefetch state type and sizing helper
// Rev 1.0
// ----------------------------------------------------------------------------
package fft_fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   typedef enum logic [1:0] {
      PF_EMPTY = 2'd0,
      PF_FETCH = 2'd1,
      PF_VALID = 2'd2
   } pf_state_e;

   // Level counter must represent 0..depth inclusive, hence one extra bit.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_fifo_sdpram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_fifo_sdpram: simple dual-port RAM, sync write, registered 1-cycle read
// Rev 1.0
// ----------------------------------------------------------------------------
module fft_fifo_sdpram #(
   parameter int c_ADDR_WIDTH = 10,
   parameter int c_DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [c_ADDR_WIDTH-1:0] wr_addr,
   input  logic [c_DATA_WIDTH-1:0] wr_data,
   input  logic                    rd_en,
   input  logic [c_ADDR_WIDTH-1:0] rd_addr,
   output logic [c_DATA_WIDTH-1:0] rd_data
);

   logic [c_DATA_WIDTH-1:0] mem [0:(1<<c_ADDR_WIDTH)-1];
   logic [c_DATA_WIDTH-1:0] rd_data_d;
   logic [c_DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Output register holds its value between reads; only it is reset, not the array.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fft_modulus_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_modulus_sync_fifo: single-clock FIFO, optional FWFT, thresholds, errors
// Rev 1.0
// ----------------------------------------------------------------------------
module fft_modulus_sync_fifo
   import fft_fifo_pkg::*;
#(
   parameter int c_DEPTH_WIDTH = 10,
   parameter int c_DATA_WIDTH  = 32,
   parameter int c_FWFT        = FIFO_STD,
   parameter int c_AF_RESET    = (2**c_DEPTH_WIDTH) - 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [c_DATA_WIDTH-1:0]  wr_data,
   input  logic                     wr_en,
   output logic                     wr_full,
   output logic                     almost_full,
   input  logic [c_DEPTH_WIDTH:0]   af_thresh,
   output logic [c_DATA_WIDTH-1:0]  rd_data,
   input  logic                     rd_en,
   output logic                     rd_empty,
   output logic                     rd_valid,
   output logic                     almost_empty,
   input  logic [c_DEPTH_WIDTH:0]   ae_thresh,
   output logic [c_DEPTH_WIDTH:0]   water_level,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int                 c_DEPTH    = 1 << c_DEPTH_WIDTH;
   localparam int                 c_LVL_W    = level_width(c_DEPTH);
   localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(c_DEPTH);
   localparam logic [c_LVL_W-1:0] c_AF_INIT  = c_LVL_W'(c_AF_RESET);
   localparam bit                 c_IS_FWFT  = (c_FWFT == FIFO_FWFT);

   logic [c_DEPTH_WIDTH-1:0] wr_ptr_d,   wr_ptr_q;
   logic [c_DEPTH_WIDTH-1:0] rd_ptr_d,   rd_ptr_q;
   logic [c_LVL_W-1:0]       level_d,    level_q;
   logic [c_LVL_W-1:0]       af_thr_d,   af_thr_q;
   logic [c_LVL_W-1:0]       ae_thr_d,   ae_thr_q;
   logic                     af_d,       af_q;
   logic                     ae_d,       ae_q;
   logic                     ovf_d,      ovf_q;
   logic                     unf_d,      unf_q;
   logic                     std_vld_d,  std_vld_q;
   pf_state_e                state_d,    state_q;

   logic                     wr_acc;
   logic                     rd_acc;
   logic                     ram_re;
   logic [c_LVL_W-1:0]       ram_cnt;
   logic [c_DATA_WIDTH-1:0]  ram_rd_data;

   assign wr_full  = (level_q == c_LVL_FULL);
   assign rd_empty = c_IS_FWFT ? (state_q != PF_VALID) : (level_q == '0);
   assign rd_valid = c_IS_FWFT ? (state_q == PF_VALID) : std_vld_q;

   always_comb begin
      wr_acc   = wr_en & ~wr_full & ~flush;
      rd_acc   = rd_en & ~rd_empty & ~flush;
      // Words still in the array: the prefetched/in-flight head is already out of it.
      ram_cnt  = level_q - c_LVL_W'(state_q != PF_EMPTY);
      ram_re   = 1'b0;
      state_d  = state_q;

      if (c_IS_FWFT) begin
         case (state_q)
            PF_EMPTY: begin
               if (ram_cnt != '0) begin
                  ram_re  = 1'b1;
                  state_d = PF_FETCH;
               end
            end
            PF_FETCH: begin
               state_d = PF_VALID;
            end
            PF_VALID: begin
               if (rd_acc) begin
                  if (ram_cnt != '0) begin
                     ram_re  = 1'b1;
                     state_d = PF_FETCH;
                  end else begin
                     state_d = PF_EMPTY;
                  end
               end
            end
            default: begin
               state_d = PF_EMPTY;
            end
         endcase
      end else begin
         ram_re  = rd_acc;
         state_d = PF_EMPTY;
      end

      wr_ptr_d  = wr_ptr_q + c_DEPTH_WIDTH'(wr_acc);
      rd_ptr_d  = rd_ptr_q + c_DEPTH_WIDTH'(ram_re);
      level_d   = level_q + c_LVL_W'(wr_acc) - c_LVL_W'(rd_acc);
      std_vld_d = rd_acc;
      af_thr_d  = af_thresh;
      ae_thr_d  = ae_thresh;
      // Flags compare the pre-edge level, so they trail water_level by one cycle.
      af_d      = (level_q >= af_thr_q);
      ae_d      = (level_q <= ae_thr_q);
      ovf_d     = ovf_q | (wr_en & wr_full);
      unf_d     = unf_q | (rd_en & rd_empty);

      if (flush) begin
         ram_re    = 1'b0;
         state_d   = PF_EMPTY;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         std_vld_d = 1'b0;
         af_d      = 1'b0;
         ae_d      = 1'b1;
         ovf_d     = 1'b0;
         unf_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         af_thr_q  <= c_AF_INIT;
         ae_thr_q  <= '0;
         af_q      <= 1'b0;
         ae_q      <= 1'b1;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         std_vld_q <= 1'b0;
         state_q   <= PF_EMPTY;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         af_thr_q  <= af_thr_d;
         ae_thr_q  <= ae_thr_d;
         af_q      <= af_d;
         ae_q      <= ae_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         std_vld_q <= std_vld_d;
         state_q   <= state_d;
      end
   end

   fft_fifo_sdpram #(
      .c_ADDR_WIDTH (c_DEPTH_WIDTH),
      .c_DATA_WIDTH (c_DATA_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_en   (ram_re),
      .rd_addr (rd_ptr_q),
      .rd_data (ram_rd_data)
   );

   assign rd_data      = ram_rd_data;
   assign water_level  = level_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule
`default_nettype wire
